// File: rtl/issue_arbiter.sv
// Dual-stream issue arbiter with a 32-entry pending-write scoreboard.
// Define ISSUE_ARB_COP_EN to enable the coprocessor (B) stream and round-robin arbitration.
module issue_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       stall,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [4:0] a_rd,
    input  logic [4:0] a_rs1,
    input  logic [4:0] a_rs2,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [4:0] b_rd,
    input  logic [4:0] b_rs1,
    input  logic [4:0] b_rs2,
    input  logic       wb_a_valid,
    input  logic [4:0] wb_a_rd,
    input  logic       wb_b_valid,
    input  logic [4:0] wb_b_rd,
    output logic       issue_valid,
    output logic       issue_sel,
    output logic [4:0] issue_rd,
    output logic       busy
);
    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;

    logic [NUM_REGS-1:0] sb;
    logic [NUM_REGS-1:0] sb_next;
    logic                a_elig;
    logic                grant_a;
    logic                grant_b;
    logic                grant;
    logic [REG_W-1:0]    grant_rd;

    // Hazard check sees only the registered scoreboard: no same-cycle write-back bypass.
    assign a_elig = rst_n & a_valid & ~stall & ~flush
                  & ~sb[a_rs1] & ~sb[a_rs2] & ~sb[a_rd];

`ifdef ISSUE_ARB_COP_EN
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } rr_state_t;

    rr_state_t rr_q;
    rr_state_t rr_d;
    logic      b_elig;

    assign b_elig = rst_n & b_valid & ~stall & ~flush
                  & ~sb[b_rs1] & ~sb[b_rs2] & ~sb[b_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= LAST_B;
        else        rr_q <= rr_d;
    end

    // Round-robin pick; pointer moves only when something is granted.
    always_comb begin
        rr_d    = rr_q;
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_elig && b_elig) begin
            if (rr_q == LAST_B) grant_a = 1'b1;
            else                grant_b = 1'b1;
        end else begin
            grant_a = a_elig;
            grant_b = b_elig;
        end
        if (grant_a)      rr_d = LAST_A;
        else if (grant_b) rr_d = LAST_B;
    end
`else
    logic unused_cop;

    assign grant_a    = a_elig;
    assign grant_b    = 1'b0;
    assign unused_cop = ^{b_valid, b_rd, b_rs1, b_rs2, wb_b_valid, wb_b_rd};
`endif

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign grant    = grant_a | grant_b;
    assign grant_rd = grant_b ? b_rd : a_rd;
    assign busy     = |sb;

    // Scoreboard update: flush wins outright, otherwise clears first so a same-cycle set wins.
    always_comb begin
        sb_next = sb;
        if (flush) begin
            sb_next = '0;
        end else begin
            if (wb_a_valid) sb_next[wb_a_rd] = 1'b0;
`ifdef ISSUE_ARB_COP_EN
            if (wb_b_valid) sb_next[wb_b_rd] = 1'b0;
`endif
            if (grant) sb_next[grant_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb          <= '0;
            issue_valid <= 1'b0;
            issue_sel   <= 1'b0;
            issue_rd    <= '0;
        end else begin
            sb          <= sb_next;
            issue_valid <= grant;
            if (grant) begin
                issue_sel <= grant_b;
                issue_rd  <= grant_rd;
            end
        end
    end
endmodule

// File: tb/tb_issue_arbiter.sv
// Scoreboard-based bench for issue_arbiter; coprocessor scenarios run when ISSUE_ARB_COP_EN is defined.
module tb_issue_arbiter;
    typedef struct packed {
        logic       sel;
        logic [4:0] rd;
    } exp_t;

    logic       clk, rst_n, flush, stall;
    logic       a_valid, a_ready, b_valid, b_ready;
    logic [4:0] a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
    logic       wb_a_valid, wb_b_valid;
    logic [4:0] wb_a_rd, wb_b_rd;
    logic       issue_valid, issue_sel, busy;
    logic [4:0] issue_rd;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    issue_arbiter dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_rs1(a_rs1), .a_rs2(a_rs2),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_rs1(b_rs1), .b_rs2(b_rs2),
        .wb_a_valid(wb_a_valid), .wb_a_rd(wb_a_rd), .wb_b_valid(wb_b_valid), .wb_b_rd(wb_b_rd),
        .issue_valid(issue_valid), .issue_sel(issue_sel), .issue_rd(issue_rd), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; stall = 0;
        a_valid = 0; a_rd = 0; a_rs1 = 0; a_rs2 = 0;
        b_valid = 0; b_rd = 0; b_rs1 = 0; b_rs2 = 0;
        wb_a_valid = 0; wb_a_rd = 0; wb_b_valid = 0; wb_b_rd = 0;
    endtask

    task automatic clean();
        idle();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0; a_valid = 1; a_rd = 5; b_valid = 1; b_rd = 6;
        #1;
        n_cmp++; if ({a_ready, b_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b exp 00", {a_ready, b_ready}); end
        n_cmp++; if ({issue_valid, issue_sel, issue_rd, busy} !== 8'h00) begin n_bad++;
            $display("FAIL reset_regs: got v=%b sel=%b rd=%0d busy=%b exp all 0", issue_valid, issue_sel, issue_rd, busy); end
        tick(); tick();
        n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL reset_hold: issue_valid=%b exp 0", issue_valid); end
        idle();
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_basic();
        a_valid = 1; a_rd = 5; a_rs1 = 1; a_rs2 = 2;
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %b exp 1", a_ready); end
        exp_q.push_back('{sel: 1'b0, rd: 5'd5});
        tick();
        a_valid = 0;
        e = exp_q.pop_front();
        n_cmp++; if ({issue_valid, issue_sel, issue_rd} !== {1'b1, e.sel, e.rd}) begin n_bad++;
            $display("FAIL basic_issue: got v=%b sel=%b rd=%0d exp v=1 sel=%b rd=%0d", issue_valid, issue_sel, issue_rd, e.sel, e.rd); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b exp 1", busy); end
    endtask

    task automatic test_raw();
        a_valid = 1; a_rd = 6; a_rs1 = 5; a_rs2 = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL raw_hold%0d: a_ready=%b exp 0", i, a_ready); end
            tick();
            n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL raw_noissue%0d: issue_valid=%b exp 0", i, issue_valid); end
        end
        wb_a_valid = 1; wb_a_rd = 5;
        #1;
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL raw_nobypass: a_ready=%b exp 0", a_ready); end
        tick();
        wb_a_valid = 0;
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL raw_release: a_ready=%b exp 1", a_ready); end
        exp_q.push_back('{sel: 1'b0, rd: 5'd6});
        tick();
        a_valid = 0;
        e = exp_q.pop_front();
        n_cmp++; if ({issue_valid, issue_sel, issue_rd} !== {1'b1, e.sel, e.rd}) begin n_bad++;
            $display("FAIL raw_issue: got v=%b sel=%b rd=%0d exp v=1 sel=%b rd=%0d", issue_valid, issue_sel, issue_rd, e.sel, e.rd); end
        clean();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL raw_clean_busy: got %b exp 0", busy); end
    endtask

    task automatic test_set_wins();
        a_valid = 1; a_rd = 7; wb_a_valid = 1; wb_a_rd = 7;
`ifdef ISSUE_ARB_COP_EN
        wb_b_valid = 1; wb_b_rd = 7;
`endif
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL setwin_ready: got %b exp 1", a_ready); end
        exp_q.push_back('{sel: 1'b0, rd: 5'd7});
        tick();
        idle();
        e = exp_q.pop_front();
        n_cmp++; if ({issue_valid, issue_sel, issue_rd} !== {1'b1, e.sel, e.rd}) begin n_bad++;
            $display("FAIL setwin_issue: got v=%b sel=%b rd=%0d exp v=1 sel=%b rd=%0d", issue_valid, issue_sel, issue_rd, e.sel, e.rd); end
        a_valid = 1; a_rd = 0; a_rs1 = 7;
        #1;
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL setwin_sb7: a_ready=%b exp 0 (SB[7] set)", a_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL setwin_busy: got %b exp 1", busy); end
        clean();
    endtask

    task automatic test_flush();
        a_valid = 1; a_rd = 3;
        exp_q.push_back('{sel: 1'b0, rd: 5'd3});
        tick();
        a_rd = 9;
        e = exp_q.pop_front();
        n_cmp++; if ({issue_valid, issue_rd} !== {1'b1, e.rd}) begin n_bad++;
            $display("FAIL flush_pre3: got v=%b rd=%0d exp v=1 rd=%0d", issue_valid, issue_rd, e.rd); end
        exp_q.push_back('{sel: 1'b0, rd: 5'd9});
        tick();
        e = exp_q.pop_front();
        n_cmp++; if ({issue_valid, issue_rd} !== {1'b1, e.rd}) begin n_bad++;
            $display("FAIL flush_pre9: got v=%b rd=%0d exp v=1 rd=%0d", issue_valid, issue_rd, e.rd); end
        flush = 1; a_rd = 10; wb_a_valid = 1; wb_a_rd = 3;
        #1;
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL flush_nogrant: a_ready=%b exp 0", a_ready); end
        tick();
        idle();
        n_cmp++; if ({issue_valid, busy} !== 2'b00) begin n_bad++;
            $display("FAIL flush_after: got v=%b busy=%b exp 0 0", issue_valid, busy); end
        a_valid = 1; a_rd = 0; a_rs1 = 9; a_rs2 = 3;
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL flush_sbclear: a_ready=%b exp 1", a_ready); end
        idle();
    endtask

    task automatic test_stall();
        a_valid = 1; a_rd = 5;
        exp_q.push_back('{sel: 1'b0, rd: 5'd5});
        tick();
        e = exp_q.pop_front();
        n_cmp++; if ({issue_valid, issue_rd} !== {1'b1, e.rd}) begin n_bad++;
            $display("FAIL stall_pre: got v=%b rd=%0d exp v=1 rd=%0d", issue_valid, issue_rd, e.rd); end
        stall = 1; a_rd = 8; wb_a_valid = 1; wb_a_rd = 5;
        #1;
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL stall_block: a_ready=%b exp 0", a_ready); end
        tick();
        n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL stall_novalid: issue_valid=%b exp 0", issue_valid); end
        stall = 0; wb_a_valid = 0; a_rs1 = 5;
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL stall_wbcleared: a_ready=%b exp 1", a_ready); end
        exp_q.push_back('{sel: 1'b0, rd: 5'd8});
        tick();
        a_valid = 0;
        e = exp_q.pop_front();
        n_cmp++; if ({issue_valid, issue_rd} !== {1'b1, e.rd}) begin n_bad++;
            $display("FAIL stall_post: got v=%b rd=%0d exp v=1 rd=%0d", issue_valid, issue_rd, e.rd); end
        clean();
    endtask

    task automatic test_midop_reset();
        a_valid = 1; a_rd = 12;
        tick();
        rst_n = 0;
        #1;
        n_cmp++; if ({issue_valid, busy, a_ready} !== 3'b000) begin n_bad++;
            $display("FAIL midrst: got v=%b busy=%b a_ready=%b exp 0 0 0", issue_valid, busy, a_ready); end
        @(negedge clk);
        rst_n = 1; a_rd = 0; a_rs1 = 12;
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_discard: a_ready=%b exp 1", a_ready); end
        idle();
        tick();
    endtask

`ifdef ISSUE_ARB_COP_EN
    task automatic test_round_robin();
        logic [3:0] pat;
        for (int pass = 0; pass < 2; pass++) begin
            a_valid = 1; b_valid = 1;
            a_rd = (pass == 0) ? 5'd3 : 5'd0;
            b_rd = (pass == 0) ? 5'd4 : 5'd0;
            wb_a_valid = (pass == 0); wb_a_rd = 3;
            wb_b_valid = (pass == 0); wb_b_rd = 4;
            pat = 4'b1010;
            for (int i = 0; i < 4; i++) begin
                #1;
                n_cmp++; if ({a_ready, b_ready} !== {~pat[i], pat[i]}) begin n_bad++;
                    $display("FAIL rr_ready p%0d c%0d: got a=%b b=%b exp a=%b b=%b", pass, i, a_ready, b_ready, ~pat[i], pat[i]); end
                exp_q.push_back('{sel: pat[i], rd: pat[i] ? b_rd : a_rd});
                tick();
                e = exp_q.pop_front();
                n_cmp++; if ({issue_valid, issue_sel, issue_rd} !== {1'b1, e.sel, e.rd}) begin n_bad++;
                    $display("FAIL rr_issue p%0d c%0d: got v=%b sel=%b rd=%0d exp v=1 sel=%b rd=%0d", pass, i, issue_valid, issue_sel, issue_rd, e.sel, e.rd); end
            end
            clean();
        end
    endtask

    task automatic test_waw_tie();
        a_valid = 1; b_valid = 1; a_rd = 9; b_rd = 9;
        #1;
        n_cmp++; if ({a_ready, b_ready} !== 2'b10) begin n_bad++; $display("FAIL waw_pick: got %b exp 10", {a_ready, b_ready}); end
        exp_q.push_back('{sel: 1'b0, rd: 5'd9});
        tick();
        a_valid = 0;
        e = exp_q.pop_front();
        n_cmp++; if ({issue_valid, issue_sel, issue_rd} !== {1'b1, e.sel, e.rd}) begin n_bad++;
            $display("FAIL waw_issue: got v=%b sel=%b rd=%0d exp v=1 sel=%b rd=%0d", issue_valid, issue_sel, issue_rd, e.sel, e.rd); end
        #1;
        n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL waw_loser: b_ready=%b exp 0", b_ready); end
        clean();
    endtask
`else
    task automatic test_no_cop();
        a_valid = 1; a_rd = 5;
        tick();
        b_valid = 1; b_rd = 4; wb_b_valid = 1; wb_b_rd = 5; a_rd = 0;
        for (int i = 0; i < 6; i++) begin
            a_valid = i[0];
            #1;
            n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL nocop_bready c%0d: got %b exp 0", i, b_ready); end
            if (a_valid) exp_q.push_back('{sel: 1'b0, rd: 5'd0});
            tick();
            n_cmp++; if (issue_sel !== 1'b0) begin n_bad++; $display("FAIL nocop_sel c%0d: got %b exp 0", i, issue_sel); end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (issue_valid !== 1'b1) begin n_bad++; $display("FAIL nocop_issue c%0d: v=%b exp 1", i, issue_valid); end
            end
        end
        a_valid = 1; a_rs1 = 5;
        #1;
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL nocop_wbb_ignored: a_ready=%b exp 0", a_ready); end
        clean();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_raw();
        test_set_wins();
        test_flush();
        test_stall();
        test_midop_reset();
`ifdef ISSUE_ARB_COP_EN
        test_round_robin();
        test_waw_tie();
`else
        test_no_cop();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/issue_arbiter.md
ISSUE_ARBITER -- requirements
Module: issue_arbiter

Interface
REQ-001 The block SHALL have the port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port FLUSH, input, 1 bit: pipeline flush.
REQ-004 The block SHALL have the port STALL, input, 1 bit: downstream stall; no grant while high.
REQ-005 The block SHALL have the ports A_VALID (input, 1 bit) and A_READY (output, 1 bit): main stream handshake.
REQ-006 The block SHALL have the ports A_RD, A_RS1, A_RS2, inputs, 5 bits each: main stream register indices.
REQ-007 The block SHALL have the ports B_VALID (input, 1 bit) and B_READY (output, 1 bit): coprocessor stream handshake.
REQ-008 The block SHALL have the ports B_RD, B_RS1, B_RS2, inputs, 5 bits each: coprocessor stream register indices.
REQ-009 The block SHALL have the ports WB_A_VALID (input, 1 bit) and WB_A_RD (input, 5 bits): main write-back completion.
REQ-010 The block SHALL have the ports WB_B_VALID (input, 1 bit) and WB_B_RD (input, 5 bits): coprocessor write-back completion.
REQ-011 The block SHALL have the port ISSUE_VALID, output, 1 bit: registered, an instruction was issued last cycle.
REQ-012 The block SHALL have the port ISSUE_SEL, output, 1 bit: registered, source of the issued instruction (0 = A, 1 = B).
REQ-013 The block SHALL have the port ISSUE_RD, output, 5 bits: registered, destination of the issued instruction.
REQ-014 The block SHALL have the port BUSY, output, 1 bit: high when any scoreboard bit is set.

Function
REQ-015 The block SHALL keep a 32-bit scoreboard SB, one pending-write bit per register; SB[0] is permanently 0.
REQ-016 Stream X SHALL be eligible when X_VALID is high, STALL is low, FLUSH is low, SB[X_RS1], SB[X_RS2] and SB[X_RD] are all 0, and no write-back is counted as clearing a hazard in the same cycle.
REQ-017 At most one grant SHALL occur per cycle, and A_READY/B_READY SHALL be combinational grant signals that are never both high.
REQ-018 When exactly one stream is eligible, that stream SHALL be granted.
REQ-019 When both streams are eligible, the stream not granted last SHALL win (round-robin); the pointer SHALL update only on a grant and SHALL reset to "last = B", so A wins first.
REQ-020 When both streams are eligible and A_RD equals B_RD with a nonzero value, the round-robin winner SHALL issue and the loser SHALL wait, held off by the WAW check on the next cycle.
REQ-021 On a grant with RD != 0, the block SHALL set SB[RD] at the clock edge.
REQ-022 Each WB_*_VALID SHALL clear SB[WB_*_RD] at the clock edge; both write-backs clearing in the same cycle SHALL be legal.
REQ-023 When a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-024 The issue registers (ISSUE_VALID, ISSUE_SEL, ISSUE_RD) SHALL have a latency of 1 cycle from the grant; ISSUE_VALID SHALL be 0 in any cycle following no grant.
REQ-025 FLUSH SHALL force no grant, clear the whole SB, and clear ISSUE_VALID at the edge, leaving the round-robin pointer unchanged; a write-back during FLUSH SHALL be harmless.
REQ-026 STALL SHALL block grants only; SB clears from write-back SHALL continue and ISSUE_VALID SHALL drop to 0.

Reset
REQ-027 While RST_N is low (asynchronous assertion), the block SHALL hold SB = 0, ISSUE_VALID = 0, ISSUE_SEL = 0, ISSUE_RD = 0, and the pointer at "last = B"; consequently BUSY = 0, and A_READY = B_READY = 0.
REQ-028 The block SHALL evaluate the first grant on the first rising edge after RST_N deasserts; reset asserted mid-operation SHALL discard all pending state.

Configuration
REQ-029 With macro ISSUE_ARB_COP_EN defined, the B stream SHALL be arbitrated as specified above.
REQ-030 With ISSUE_ARB_COP_EN undefined, B_READY SHALL be tied to 0, the B inputs and WB_B_* SHALL be ignored, ISSUE_SEL SHALL be constant 0, and the round-robin logic SHALL be absent.

Verification
REQ-031 A bench SHALL drive reset release, then A_VALID=1 with RD=5 and RS=1,2, and SHALL see A_READY=1 that cycle, then ISSUE_VALID=1, ISSUE_SEL=0, ISSUE_RD=5, and BUSY=1.
REQ-032 A bench SHALL issue A with RD=5, then drive A with RS1=5, and SHALL see A_READY=0 until WB_A_VALID with RD=5, then A_READY=1 in the following cycle.
REQ-033 A bench SHALL drive A (RD=3) and B (RD=4) valid and independent for 4 cycles, and SHALL see grants alternate A,B,A,B.
REQ-034 A bench SHALL drive a grant with RD=7 and WB_B_RD=7 in the same cycle, and SHALL see SB[7]=1 afterwards.
REQ-035 A bench SHALL assert FLUSH with SB holding bits 3 and 9 set, and SHALL see SB=0, BUSY=0, and ISSUE_VALID=0 on the next cycle.
REQ-036 A bench SHALL build the block without ISSUE_ARB_COP_EN and drive B_VALID=1 continuously, and SHALL see B_READY=0 and ISSUE_SEL=0 always.
